// File: rtl/cvt_batch_scheduler.sv
// Thread-convergence batch scheduler: a table of per-BB pending-thread bitmaps
// fed by branch tokens, drained one basic block per batch as CUDA thread IDs.
module cvt_batch_scheduler #(
  parameter int NUM_THREADS = 64,
  parameter int NUM_BB      = 32,
  parameter int TID_W       = 10,
  localparam int LANE_W     = $clog2(NUM_THREADS),
  localparam int BB_W       = $clog2(NUM_BB)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [BB_W-1:0]        cfg_bb,
  input  logic [TID_W-1:0]       cfg_base,
  input  logic                   tok_valid,
  output logic                   tok_ready,
  input  logic [LANE_W-1:0]      tok_lane,
  input  logic [BB_W-1:0]        tok_target,
  input  logic                   tok_exit,
  input  logic                   sched_go,
  input  logic                   sched_force,
  input  logic [BB_W-1:0]        sched_force_bb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TID_W-1:0]       out_tid,
  output logic [LANE_W-1:0]      out_lane,
  output logic [BB_W-1:0]        cur_bb,
  output logic                   batch_done,
  output logic [LANE_W:0]        batch_len,
  output logic                   threads_terminated,
  input  logic [BB_W-1:0]        rd_bb,
  output logic [NUM_THREADS-1:0] rd_bitmap
);

  // Output handshake: a TID transfers on a cycle where out_valid && out_ready;
  // out_tid/out_lane are held unchanged while out_valid is high and out_ready low.
  typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_THREADS-1:0] bitmap_q [NUM_BB];
  logic [NUM_THREADS-1:0] bitmap_d [NUM_BB];
  logic [TID_W-1:0]       base_q   [NUM_BB];
  logic [TID_W-1:0]       base_d   [NUM_BB];
  logic [LANE_W:0]        term_cnt_q, term_cnt_d;
  logic                   term_q, term_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANE_W-1:0]      out_lane_q, out_lane_d;
  logic [TID_W-1:0]       out_tid_q, out_tid_d;
  logic [BB_W-1:0]        cur_bb_q, cur_bb_d;
  logic                   batch_done_q, batch_done_d;
  logic [LANE_W:0]        batch_len_q, batch_len_d;
  logic [LANE_W:0]        emit_cnt_q, emit_cnt_d;
  logic [NUM_THREADS-1:0] rd_bitmap_q, rd_bitmap_d;

  logic [BB_W-1:0]        pend_bb;
  logic [BB_W-1:0]        sel_bb;
  logic [NUM_THREADS-1:0] sel_map;
  logic [NUM_THREADS-1:0] nxt_map;
  logic [LANE_W-1:0]      sel_lane;
  logic [LANE_W-1:0]      nxt_lane;
  logic                   hs;

  function automatic logic [LANE_W-1:0] lowest_lane(input logic [NUM_THREADS-1:0] m);
    lowest_lane = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = LANE_W'(i);
    end
  endfunction

  always_comb begin
    pend_bb = '0;
    for (int b = NUM_BB - 1; b >= 0; b--) begin
      if (bitmap_q[b] != '0) pend_bb = BB_W'(b);
    end
  end

  assign sel_bb   = sched_force ? sched_force_bb : pend_bb;
  assign sel_map  = bitmap_q[sel_bb];
  assign sel_lane = lowest_lane(sel_map);
  assign hs       = (state_q == EMIT) && out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    bitmap_d     = bitmap_q;
    base_d       = base_q;
    term_cnt_d   = term_cnt_q;
    out_valid_d  = out_valid_q;
    out_lane_d   = out_lane_q;
    out_tid_d    = out_tid_q;
    cur_bb_d     = cur_bb_q;
    batch_done_d = 1'b0;
    batch_len_d  = batch_len_q;
    emit_cnt_d   = emit_cnt_q;
    rd_bitmap_d  = bitmap_q[rd_bb];
    nxt_map      = '0;
    nxt_lane     = '0;

    if (state_q == IDLE && cfg_valid) begin
      base_d[cfg_bb]   = cfg_base;
      bitmap_d[cfg_bb] = '0;
    end
    if (hs) bitmap_d[cur_bb_q][out_lane_q] = 1'b0;
    // Applied after the handshake clear so a same-cycle token re-arms the lane.
    if (tok_valid && !tok_exit) bitmap_d[tok_target][tok_lane] = 1'b1;
    if (tok_valid && tok_exit && term_cnt_q != (LANE_W+1)'(NUM_THREADS))
      term_cnt_d = term_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (sched_go && !cfg_valid) state_d = SELECT;
      end
      SELECT: begin
        cur_bb_d   = sel_bb;
        emit_cnt_d = '0;
        if (sel_map == '0) begin
          state_d      = DONE;
          batch_done_d = 1'b1;
          batch_len_d  = '0;
        end else begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_lane_d  = sel_lane;
          out_tid_d   = base_q[sel_bb] + TID_W'(sel_lane);
        end
      end
      EMIT: begin
        if (hs) begin
          emit_cnt_d = emit_cnt_q + 1'b1;
          nxt_map    = bitmap_d[cur_bb_q];
          nxt_lane   = lowest_lane(nxt_map);
          if (nxt_map != '0) begin
            out_lane_d = nxt_lane;
            out_tid_d  = base_q[cur_bb_q] + TID_W'(nxt_lane);
          end else begin
            out_valid_d  = 1'b0;
            state_d      = DONE;
            batch_done_d = 1'b1;
            batch_len_d  = emit_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cfg_ready_d = (state_d == IDLE);
    term_d      = term_q | (term_cnt_d == (LANE_W+1)'(NUM_THREADS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bitmap_q     <= '{default: '0};
      base_q       <= '{default: '0};
      term_cnt_q   <= '0;
      term_q       <= 1'b0;
      cfg_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      out_lane_q   <= '0;
      out_tid_q    <= '0;
      cur_bb_q     <= '0;
      batch_done_q <= 1'b0;
      batch_len_q  <= '0;
      emit_cnt_q   <= '0;
      rd_bitmap_q  <= '0;
    end else begin
      state_q      <= state_d;
      bitmap_q     <= bitmap_d;
      base_q       <= base_d;
      term_cnt_q   <= term_cnt_d;
      term_q       <= term_d;
      cfg_ready_q  <= cfg_ready_d;
      out_valid_q  <= out_valid_d;
      out_lane_q   <= out_lane_d;
      out_tid_q    <= out_tid_d;
      cur_bb_q     <= cur_bb_d;
      batch_done_q <= batch_done_d;
      batch_len_q  <= batch_len_d;
      emit_cnt_q   <= emit_cnt_d;
      rd_bitmap_q  <= rd_bitmap_d;
    end
  end

  assign cfg_ready          = cfg_ready_q;
  assign tok_ready          = 1'b1;
  assign out_valid          = out_valid_q;
  assign out_tid            = out_tid_q;
  assign out_lane           = out_lane_q;
  assign cur_bb             = cur_bb_q;
  assign batch_done         = batch_done_q;
  assign batch_len          = batch_len_q;
  assign threads_terminated = term_q;
  assign rd_bitmap          = rd_bitmap_q;

endmodule
